// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial arithmetic controllers (subtract today,
// add/compare later).
//   state_t   : controller FSM state encoding
//   cnt_width : bit-position counter width for an n-bit operand, never below 1
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// 1-bit full subtractor: d = x - y - z, bo = borrow-out.
//   x  in  minuend bit
//   y  in  subtrahend bit
//   z  in  borrow-in
//   d  out difference bit
//   bo out borrow-out
module fs_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ z;
  assign bo = (~x & y) | (~(x ^ y) & z);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial N-bit subtractor controller. One shared fs_cell is sequenced over
// the operand bits, LSB first, to compute diff = a - b - bin (mod 2^N).
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   start  in  request; accepted only when idle
//   a, b   in  minuend / subtrahend, captured on accepted start
//   bin    in  borrow-in, captured on accepted start
//   diff   out registered result, held until the next completion
//   bout   out registered final borrow-out
//   busy   out high while an operation is in progress
//   done   out one-cycle pulse coincident with the new diff/bout
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-1:0]   res_sr;
  logic [N-1:0]   res_nxt;
  logic           brw;
  logic           cell_d;
  logic           cell_bo;
  logic           done_q;

  fs_cell u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .z  (brw),
    .d  (cell_d),
    .bo (cell_bo)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: busy is a pure state decode; done is registered off the DONE
  // state so it rises together with the diff/bout update.
  always_comb begin
    busy = (state != IDLE);
    done = done_q;
  end

  // New result bit enters at the MSB; written as shift-then-insert so the
  // same expression is valid for N == 1.
  always_comb begin
    res_nxt        = res_sr >> 1;
    res_nxt[N-1]   = cell_d;
  end

  // Datapath: operand/result shift registers, borrow, counter, outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            brw    <= bin;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          res_sr <= res_nxt;
          brw    <= cell_bo;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt    <= cnt + 1'b1;
        end
        DONE: begin
          diff <= res_sr;
          bout <= brw;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: one N=4 and one N=1 instance share
// clock and reset. Stimulus pushes the hand-computed result and the cycle at
// which done must appear; monitors pop and compare on every done pulse.
module tb_serial_sub_ctrl;

  localparam int unsigned N4 = 4;
  localparam int unsigned N1 = 1;

  typedef struct {
    logic [3:0]  d;
    logic        bo;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start4, start1;
  logic [3:0]  a4, b4, diff4;
  logic [0:0]  a1, b1, diff1;
  logic        bin4, bin1, bout4, bout1, busy4, busy1, done4, done1;

  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  exp_t        q4[$];
  exp_t        q1[$];

  serial_sub_ctrl #(.N(N4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
  );

  serial_sub_ctrl #(.N(N1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .diff(diff1), .bout(bout1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (mon_en && done4) begin
      if (q4.size() == 0) begin
        chk("done4_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("diff4", 32'(diff4), 32'(e.d));
        chk("bout4", 32'(bout4), 32'(e.bo));
        chk("done4_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && done1) begin
      if (q1.size() == 0) begin
        chk("done1_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("diff1", 32'(diff1), 32'(e.d));
        chk("bout1", 32'(bout1), 32'(e.bo));
        chk("done1_cycle", cyc, e.cyc);
      end
    end
  end

  // Called just after a negedge; returns just after the negedge where the DUT
  // is idle again.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                     input logic [3:0] ed, input logic eb);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    q4.push_back('{ed, eb, cyc + N4 + 2});
    @(negedge clk);
    start4 = 1'b0;
    chk("busy4_after_start", 32'(busy4), 32'd1);
    repeat (N4 + 2) @(negedge clk);
  endtask

  logic [1:0] n1_exp [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_diff4", 32'(diff4), 32'd0);
    chk("rst_bout4", 32'(bout4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic subtractions, N=4
    op4(4'd5, 4'd3, 1'b0, 4'd2, 1'b0);
    op4(4'd3, 4'd5, 1'b0, 4'hE, 1'b1);
    op4(4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    op4(4'd9, 4'd9, 1'b1, 4'hF, 1'b1);
    op4(4'd15, 4'd0, 1'b1, 4'hE, 1'b0);

    // Start re-pulsed mid-SHIFT with new operands: ignored
    a4 = 4'd5; b4 = 4'd3; bin4 = 1'b0; start4 = 1'b1;
    q4.push_back('{4'd2, 1'b0, cyc + N4 + 2});
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (N4) @(negedge clk);
    chk("busy4_after_ignored", 32'(busy4), 32'd0);

    // Reset mid-SHIFT: abort, outputs cleared, no done
    a4 = 4'd3; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy4", 32'(busy4), 32'd0);
    chk("abort_diff4", 32'(diff4), 32'd0);
    chk("abort_bout4", 32'(bout4), 32'd0);
    repeat (N4 + 2) @(negedge clk);

    // Start held high: back-to-back ops spaced N+2 cycles
    a4 = 4'd8; b4 = 4'd1; bin4 = 1'b0; start4 = 1'b1;
    q4.push_back('{4'd7, 1'b0, cyc + N4 + 2});
    q4.push_back('{4'd7, 1'b0, cyc + 2 * (N4 + 2)});
    repeat (N4 + 3) @(negedge clk);
    start4 = 1'b0;
    repeat (N4 + 3) @(negedge clk);

    // N=1: all eight input combinations
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      a1 = v[2]; b1 = v[1]; bin1 = v[0]; start1 = 1'b1;
      q1.push_back('{{3'b000, n1_exp[i][1]}, n1_exp[i][0], cyc + N1 + 2});
      @(negedge clk); start1 = 1'b0;
      repeat (N1 + 1) @(negedge clk);
    end

    // Bounded drain of outstanding expectations
    for (int t = 0; t < 20 && (q4.size() != 0 || q1.size() != 0); t++) @(negedge clk);
    chk("drain_q4", q4.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
